// File: rtl/babbage_pkg.sv
// Shared definitions for the Babbage difference-engine family: default
// sample/coefficient widths, the fit state encoding and the divide-by-6 step.
package babbage_pkg;

    localparam int W_Y = 33;  // sample width, two's complement
    localparam int W_A = 8;   // unsigned coefficient width

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DIFF,
        DIV,
        FIN,
        DONE
    } state_t;

    // One restoring-division step by 6: shift din into the partial remainder,
    // subtract 6 if it fits. Returns {quotient_bit, new_remainder}.
    function automatic logic [3:0] div6_step(input logic [2:0] rem, input logic din);
        logic [3:0] t;
        t = {rem, din};
        if (t >= 4'd6) begin
            return {1'b1, 3'(t - 4'd6)};
        end
        return {1'b0, t[2:0]};
    endfunction

endpackage

// File: rtl/babbage_div6.sv
// Serial restoring divider by 6, sign-magnitude with truncation toward zero.
// The first quotient bit is resolved on the start edge, so N quotient bits
// take N cycles in total and done pulses in the cycle after the last step.
module babbage_div6
    import babbage_pkg::*;
#(
    parameter int N = babbage_pkg::W_Y + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [N-1:0] dividend,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] quotient,
    output logic signed [3:0]   remainder
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  shreg;   // remaining dividend bits shift out, quotient bits shift in
    logic [2:0]    rem;
    logic          neg;
    logic [CW-1:0] cnt;
    logic [N-1:0]  mag;
    logic [3:0]    first_step;
    logic [3:0]    next_step;

    // Magnitude of the dividend and the two possible step results.
    // NOTE: every signal of this block is assigned on every pass, so no latch is inferred.
    always_comb begin
        mag        = dividend[N-1] ? -dividend : dividend;
        first_step = div6_step(3'd0, mag[N-1]);
        next_step  = div6_step(rem, shreg[N-1]);
    end

    // Load on start, then one quotient bit per cycle until the count runs out.
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            shreg <= '0;
            neg   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shreg <= {mag[N-2:0], first_step[3]};
                rem   <= first_step[2:0];
                neg   <= dividend[N-1];
                cnt   <= CW'(N - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                shreg <= {shreg[N-2:0], next_step[3]};
                rem   <= next_step[2:0];
                cnt   <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = neg ? -$signed(shreg) : $signed(shreg);
    assign remainder = neg ? -$signed({1'b0, rem}) : $signed({1'b0, rem});

endmodule

// File: rtl/babbage_fit.sv
// Recovers the coefficients a3..a0 of a cubic from four consecutive samples
// p(0)..p(3) using forward differences and a serial divide-by-6.
// Optional macro BABBAGE_FIT_CHECK_EN enables the exact/in-range check on err;
// without it err is tied low.
module babbage_fit
    import babbage_pkg::*;
#(
    parameter int W_Y = babbage_pkg::W_Y,
    parameter int W_A = babbage_pkg::W_A
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W_Y-1:0] y,
    input  logic           y_val,
    output logic           y_rdy,
    output logic [W_A-1:0] a3,
    output logic [W_A-1:0] a2,
    output logic [W_A-1:0] a1,
    output logic [W_A-1:0] a0,
    output logic           coef_val,
    output logic           err
);

    localparam int WD = W_Y + 2;  // difference width

    state_t                state;
    logic [1:0]            cnt;
    logic signed [W_Y-1:0] p [4];
    logic signed [WD-1:0]  d1_r, d2_r, d3_r;
    logic signed [WD-1:0]  s0, s1, s2, s3;
    logic signed [WD-1:0]  d1_c, d2_c, d3_c;
    logic signed [WD-1:0]  diff_c, a3_c, a2_c, a1_c, a0_c;
    logic                  div_start, div_busy, div_done;
    logic signed [WD-1:0]  div_quot;
    logic signed [3:0]     div_rem;

    assign div_start = (state == DIFF) && !div_busy;

    babbage_div6 #(.N(WD)) u_div6 (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (d3_c),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Forward differences of the stored samples and the final coefficient solve.
    always_comb begin
        s0     = {{2{p[0][W_Y-1]}}, p[0]};
        s1     = {{2{p[1][W_Y-1]}}, p[1]};
        s2     = {{2{p[2][W_Y-1]}}, p[2]};
        s3     = {{2{p[3][W_Y-1]}}, p[3]};
        d1_c   = s1 - s0;
        d2_c   = s2 - (s1 <<< 1) + s0;
        d3_c   = s3 - ((s2 <<< 1) + s2) + ((s1 <<< 1) + s1) - s0;
        diff_c = d2_r - d3_r;
        a3_c   = div_quot;
        a2_c   = diff_c >>> 1;  // exact when diff_c is even; odd values are flagged as errors
        a1_c   = d1_r - a3_c - a2_c;
        a0_c   = s0;
    end

    // Sample capture and difference registers.
    // NOTE: sample and difference storage is not reset; it is always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (y_val && y_rdy) begin
            p[cnt] <= y;
        end
        if (state == DIFF) begin
            d1_r <= d1_c;
            d2_r <= d2_c;
            d3_r <= d3_c;
        end
    end

    // Control FSM with registered y_rdy, coef_val and coefficient outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            y_rdy    <= 1'b1;
            coef_val <= 1'b0;
            a3       <= '0;
            a2       <= '0;
            a1       <= '0;
            a0       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (y_val) begin
                        cnt   <= 2'd1;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (y_val) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= DIFF;
                            y_rdy <= 1'b0;
                        end
                    end
                end
                DIFF: state <= DIV;
                DIV: begin
                    if (div_done) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    a3       <= a3_c[W_A-1:0];
                    a2       <= a2_c[W_A-1:0];
                    a1       <= a1_c[W_A-1:0];
                    a0       <= a0_c[W_A-1:0];
                    coef_val <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    coef_val <= 1'b0;
                    y_rdy    <= 1'b1;
                    cnt      <= 2'd0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    y_rdy <= 1'b1;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

`ifdef BABBAGE_FIT_CHECK_EN
    logic err_r;
    logic err_c;

    function automatic logic out_of_range(input logic [WD-1:0] c);
        return |c[WD-1:W_A];
    endfunction

    // Inexact division, odd second-difference residue or out-of-range coefficient.
    always_comb begin
        err_c = (div_rem != 4'sd0) | diff_c[0] |
                out_of_range(a3_c) | out_of_range(a2_c) |
                out_of_range(a1_c) | out_of_range(a0_c);
    end

    // Error flag is captured together with the coefficients.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (state == FIN) begin
            err_r <= err_c;
        end
    end

    assign err = err_r;
`else
    logic unused_bits;
    assign unused_bits = ^{div_rem, a3_c[WD-1:W_A], a2_c[WD-1:W_A],
                           a1_c[WD-1:W_A], a0_c[WD-1:W_A]};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_babbage_fit.sv
// Self-checking bench for babbage_fit: table of sample/coefficient vectors,
// scoreboard of expected results, and hand sequences for reset and flooding.
module tb_babbage_fit;

    localparam int W_Y = 33;
    localparam int W_A = 8;
    localparam int LAT = W_Y + 4;
`ifdef BABBAGE_FIT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W_Y-1:0] y = '0;
    logic           y_val = 1'b0;
    logic           y_rdy;
    logic [W_A-1:0] a3, a2, a1, a0;
    logic           coef_val;
    logic           err;

    typedef struct {
        longint s0, s1, s2, s3;
        int     a3, a2, a1, a0;   // expected low W_A bits
        bit     err_chk;          // expected err when the check is built in
        bit     chk_coef;         // coefficients are meaningful for this vector
    } vec_t;

    typedef struct {
        logic [W_A-1:0] a3, a2, a1, a0;
        bit             err;
        bit             chk_coef;
        int             cap;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    babbage_fit #(.W_Y(W_Y), .W_A(W_A)) dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .y_val    (y_val),
        .y_rdy    (y_rdy),
        .a3       (a3),
        .a2       (a2),
        .a1       (a1),
        .a0       (a0),
        .coef_val (coef_val),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: every coef_val pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && coef_val) begin
            if (sb.size() == 0) begin
                check("unexpected_coef_val", coef_val, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.chk_coef) begin
                    check("a3", a3, mon_e.a3);
                    check("a2", a2, mon_e.a2);
                    check("a1", a1, mon_e.a1);
                    check("a0", a0, mon_e.a0);
                end
                check("err", err, mon_e.err);
                check("latency", cyc - mon_e.cap, LAT);
            end
        end
    end

    task automatic send(input logic [W_Y-1:0] v, input int gap, output int cap);
        int w = 0;
        while (!y_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!y_rdy) check("y_rdy_timeout", y_rdy, 1'b1);
        y     = v;
        y_val = 1'b1;
        cap   = cyc + 1;
        @(negedge clk);
        y_val = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_fit(input vec_t v, input int gb, input bit push, input bit wait_done);
        logic [W_Y-1:0] s [4];
        int   cap;
        exp_t e;
        s[0] = W_Y'(v.s0);
        s[1] = W_Y'(v.s1);
        s[2] = W_Y'(v.s2);
        s[3] = W_Y'(v.s3);
        for (int i = 0; i < 4; i++) send(s[i], (gb + i) % 6, cap);
        if (push) begin
            e.a3       = W_A'(v.a3);
            e.a2       = W_A'(v.a2);
            e.a1       = W_A'(v.a1);
            e.a0       = W_A'(v.a0);
            e.err      = CHECK_EN ? v.err_chk : 1'b0;
            e.chk_coef = v.chk_coef;
            e.cap      = cap;
            sb.push_back(e);
        end
        if (wait_done) begin
            int w = 0;
            while (sb.size() != 0 && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (sb.size() != 0) begin
                check("result_timeout", sb.size(), 0);
                sb.delete();
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_y_rdy"}, y_rdy, 1'b1);
        check({tag, "_coef_val"}, coef_val, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_coefs"}, {a3, a2, a1, a0}, '0);
    endtask

    initial begin
        int dummy;
        vec_t zero_v;

        //          s0   s1    s2    s3   a3   a2   a1   a0  err chk
        vecs[0] = '{4,   10,   26,   58,    1,   2,   3,   4, 0, 1};
        vecs[1] = '{255, 1020, 3825, 10200, 255, 255, 255, 255, 0, 1};
        vecs[2] = '{0,   1,    0,    0,     0,   0,   0,   0, 1, 0};
        vecs[3] = '{7,   14,   33,   76,    2,   0,   5,   7, 0, 1};
        vecs[4] = '{3,   3,    5,    9,     0,   1, 255,   3, 1, 1};
        vecs[5] = '{256, 256,  256,  256,   0,   0,   0,   0, 1, 1};
        vecs[6] = '{0,   0,    0,    -6,  255,   3, 254,   0, 1, 1};
        zero_v  = '{0,   0,    0,    0,     0,   0,   0,   0, 0, 1};

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        @(negedge clk);

        // Table of vectors with varying gaps between samples.
        for (int i = 0; i < 7; i++) run_fit(vecs[i], i % 6, 1'b1, 1'b1);

        // All-zero polynomial with gaps 0..5.
        run_fit(zero_v, 0, 1'b1, 1'b1);
        run_fit(zero_v, 2, 1'b1, 1'b1);

        // Reset in the middle of the divide discards the fit and clears outputs.
        run_fit(vecs[0], 0, 1'b1, 1'b1);
        run_fit(vecs[3], 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_state("mid_div_reset");
        repeat (60) @(negedge clk);

        // Reset after two samples: only the post-reset samples form the fit.
        send(W_Y'(7), 0, dummy);
        send(W_Y'(9), 0, dummy);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_fit(vecs[0], 2, 1'b1, 1'b1);

        // Flood y_val while busy; those samples must be ignored.
        run_fit(vecs[1], 0, 1'b1, 1'b0);
        check("busy_y_rdy", y_rdy, 1'b0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (coef_val) break;
            y_val = 1'b1;
            y     = W_Y'($urandom);
        end
        y_val = 1'b0;
        check("flood_result_seen", coef_val, 1'b1);
        @(negedge clk);
        if (sb.size() != 0) begin
            check("flood_pending", sb.size(), 0);
            sb.delete();
        end
        run_fit(vecs[0], 1, 1'b1, 1'b1);

        repeat (60) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
